// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: op codes and arbiter state encodings shared by the modular-arithmetic blocks.
package mod_arith_pkg;

   typedef enum logic [2:0] {
      X_MUL_Y = 3'd0,
      X_MUL_X = 3'd1,
      X_SQR   = 3'd2,
      X_SUB_Y = 3'd3,
      X_ADD_Y = 3'd4,
      X_INV   = 3'd5,
      X_LDX   = 3'd6,
      X_RTB   = 3'd7
   } arith_op_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_e;

   localparam int ARITH_OPW = 3;

endpackage

// File: rtl/mod_arith_rr_pick.sv
// mod_arith_rr_pick: first eligible index at or after the pointer, wrapping modulo NREQ.
module mod_arith_rr_pick #(
   parameter int NREQ = 2,
   parameter int IDXW = 1
) (
   input  logic [NREQ-1:0] elig_i,
   input  logic [IDXW-1:0] ptr_i,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);

   // scan from the farthest offset down so the nearest eligible index is written last
   always_comb begin
      idx_o = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (elig_i[(int'(ptr_i) + k) % NREQ]) idx_o = IDXW'((int'(ptr_i) + k) % NREQ);
   end

   assign any_o = |elig_i;

endmodule

// File: rtl/mod_arith_arb.sv
// mod_arith_arb: round-robin sharing of one modular-arithmetic unit between NREQ requesters.
// MOD_ARITH_ARB_LOCK_EN adds a requester lock that keeps accumulator chains on one owner.
module mod_arith_arb
   import mod_arith_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDXW = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [ARITH_OPW*NREQ-1:0] req_op,
   input  logic [NREQ-1:0]           req_opt_mod,
   input  logic [NREQ-1:0]           req_opt_accx,
   input  logic [NREQ-1:0]           req_opt_accy,
   input  logic [NREQ-1:0]           req_lock,
   output logic [NREQ-1:0]           req_grant,
   output logic [NREQ-1:0]           req_done,
   output logic [NREQ-1:0]           req_abort,
   output logic [ARITH_OPW-1:0]      arith_op,
   output logic                      arith_en,
   output logic                      arith_opt_mod,
   output logic                      arith_opt_accx,
   output logic                      arith_opt_accy,
   output logic                      arith_clear,
   input  logic                      arith_ready,
   output logic                      busy,
   output logic [IDXW-1:0]           owner
);

   arb_state_e      state_q, state_d;
   logic [IDXW-1:0] rr_q, rr_d, owner_q, owner_d, win;
   logic [NREQ-1:0] elig;
   logic            any, issue, fin, kill;

`ifdef MOD_ARITH_ARB_LOCK_EN
   logic            lock_q, lock_d;
   logic [IDXW-1:0] lock_idx_q, lock_idx_d;
   assign elig = lock_q ? req_valid & (NREQ'(1) << lock_idx_q) : req_valid;
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign elig = req_valid;
`endif

   mod_arith_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
      .elig_i(elig),
      .ptr_i (rr_q),
      .idx_o (win),
      .any_o (any)
   );

   // clear outranks both issue and completion
   assign issue = !rst && !clear && arith_ready && any && state_q == ARB_IDLE;
   assign fin   = !rst && !clear && arith_ready && state_q == ARB_RUN;
   assign kill  = !rst && clear && state_q == ARB_RUN;

   assign arith_en       = issue;
   assign arith_op       = issue ? req_op[ARITH_OPW*int'(win) +: ARITH_OPW] : '0;
   assign arith_opt_mod  = issue && req_opt_mod[win];
   assign arith_opt_accx = issue && req_opt_accx[win];
   assign arith_opt_accy = issue && req_opt_accy[win];
   assign arith_clear    = !rst && clear;
   assign req_grant      = issue ? NREQ'(1) << win : '0;
   assign req_done       = fin ? NREQ'(1) << owner_q : '0;
   assign req_abort      = kill ? NREQ'(1) << owner_q : '0;
   assign busy           = state_q == ARB_RUN;
   assign owner          = owner_q;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      if (issue) begin
         state_d = ARB_RUN;
         owner_d = win;
         rr_d    = win == IDXW'(NREQ - 1) ? '0 : win + 1'b1;
      end else if (fin || kill) begin
         state_d = ARB_IDLE;
      end
   end

`ifdef MOD_ARITH_ARB_LOCK_EN
   // while locked only lock_idx can win, so any grant re-evaluates the lock from that requester
   assign lock_d     = clear ? 1'b0 : issue ? req_lock[win] : lock_q;
   assign lock_idx_d = issue ? win : lock_idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         rr_q    <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
      end
   end

endmodule

// File: tb/tb_mod_arith_arb.sv
// tb_mod_arith_arb: scoreboard bench for mod_arith_arb with a fixed-latency unit model.
module tb_mod_arith_arb;
   import mod_arith_pkg::*;

   localparam int NREQ = 2;
   localparam int IDXW = 1;

   logic clk = 1'b0, rst = 1'b1, clear = 1'b0, nr_force = 1'b0;
   logic [NREQ-1:0] req_valid = '0, req_lock = '0;
   logic [NREQ-1:0] req_opt_mod = 2'b10, req_opt_accx = 2'b01, req_opt_accy = 2'b11;
   logic [3*NREQ-1:0] req_op = '0;
   logic [NREQ-1:0] req_grant, req_done, req_abort, gnt_seen;
   logic [2:0] arith_op;
   logic arith_en, arith_opt_mod, arith_opt_accx, arith_opt_accy, arith_clear, arith_ready, busy;
   logic [IDXW-1:0] owner;

   int pend[NREQ];
   logic [2:0] op_r[NREQ];
   int cnt = 0;
   logic [10:0] exp_q[$];
   int ntests = 0, nfail = 0;

   always #5 clk = ~clk;

   mod_arith_arb #(.NREQ(NREQ), .IDXW(IDXW)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .req_valid(req_valid), .req_op(req_op), .req_opt_mod(req_opt_mod),
      .req_opt_accx(req_opt_accx), .req_opt_accy(req_opt_accy), .req_lock(req_lock),
      .req_grant(req_grant), .req_done(req_done), .req_abort(req_abort),
      .arith_op(arith_op), .arith_en(arith_en), .arith_opt_mod(arith_opt_mod),
      .arith_opt_accx(arith_opt_accx), .arith_opt_accy(arith_opt_accy),
      .arith_clear(arith_clear), .arith_ready(arith_ready), .busy(busy), .owner(owner)
   );

   // unit model: ready low for 3 cycles after issue, 1 cycle after clear
   always @(posedge clk)
      if (rst) cnt <= 0;
      else if (arith_clear) cnt <= 1;
      else if (arith_en) cnt <= 3;
      else if (cnt > 0) cnt <= cnt - 1;
   assign arith_ready = cnt == 0 && !nr_force;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] oh2i(input logic [NREQ-1:0] v);
      oh2i = '0;
      for (int i = 0; i < NREQ; i++) if (v[i]) oh2i = 3'(i);
   endfunction

   function automatic logic [10:0] eg(input int i, input logic [2:0] op);
      return {2'd1, 3'(i), op, req_opt_mod[i], req_opt_accx[i], req_opt_accy[i]};
   endfunction
   function automatic logic [10:0] ed(input int i);
      return {2'd2, 3'(i), 6'd0};
   endfunction
   function automatic logic [10:0] ea(input int i);
      return {2'd3, 3'(i), 6'd0};
   endfunction

   // requesters: keep valid while work is pending, consume one unit per grant
   initial forever begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_seen[i]) pend[i]--;
         req_valid[i] = pend[i] > 0;
         req_op[3*i +: 3] = op_r[i];
      end
   end

   always @(negedge clk) begin
      logic [10:0] ev;
      gnt_seen = req_grant;
      check("en_vs_grant", arith_en, |req_grant);
      if (|{req_grant, req_done, req_abort}) begin
         check("onehot", $countones({req_grant, req_done, req_abort}), 1);
         ev = req_grant != 0 ? {2'd1, oh2i(req_grant), arith_op, arith_opt_mod, arith_opt_accx, arith_opt_accy}
            : req_done != 0 ? {2'd2, oh2i(req_done), 6'd0} : {2'd3, oh2i(req_abort), 6'd0};
         if (exp_q.size() == 0) check("unexpected_ev", 32'(ev), 0);
         else check("event", 32'(ev), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic wait_grant();
      int n = 0;
      @(negedge clk);
      while (req_grant == 0 && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("grant_timeout", 0, 1);
   endtask

   task automatic wait_quiet();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy || pend[0] != 0 || pend[1] != 0) && n < 300) begin
         n++; @(negedge clk);
      end
      if (n >= 300) check("quiet_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < NREQ; i++) begin pend[i] = 0; op_r[i] = X_MUL_Y; end
      rst = 1'b1; clear = 1'b1;
      op_r[0] = X_ADD_Y; pend[0] += 1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      check("rst_clear", arith_clear, 0);
      check("rst_grant", req_grant, 0);
      // single X_ADD_Y from req0
      exp_q.push_back(eg(0, X_ADD_Y)); exp_q.push_back(ed(0));
      tick(); clear = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("t1_en", arith_en, 1);
      check("t1_op", arith_op, 3'b100);
      check("t1_grant", req_grant, 2'b01);
      @(negedge clk);
      check("t1_busy", busy, 1);
      n = 1;
      while (req_done == 0 && n < 20) begin @(negedge clk); n++; end
      check("t1_done_lat", n, 4);
      check("t1_done", req_done, 2'b01);
      wait_quiet();
      // alternating grants with rr starting at 0
      do_reset();
      op_r[0] = X_MUL_X; op_r[1] = X_SQR;
      pend[0] += 2; pend[1] += 2;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(eg(0, X_MUL_X)); exp_q.push_back(ed(0));
         exp_q.push_back(eg(1, X_SQR));   exp_q.push_back(ed(1));
      end
      wait_quiet();
      // clear while owner 1 runs, req0 pending
      op_r[1] = X_SUB_Y; pend[1] += 1;
      exp_q.push_back(eg(1, X_SUB_Y)); exp_q.push_back(ea(1)); exp_q.push_back(eg(0, X_MUL_X)); exp_q.push_back(ed(0));
      wait_grant();
      tick(); pend[0] += 1; clear = 1'b1;
      @(negedge clk);
      check("clr_pass", arith_clear, 1);
      check("clr_abort", req_abort, 2'b10);
      check("clr_nodone", req_done, 0);
      tick(); clear = 1'b0;
      @(negedge clk);
      check("clr_idle", busy, 0);
      wait_quiet();
      // clear coinciding with ready in RUN: abort, not done
      pend[1] += 1;
      exp_q.push_back(eg(1, X_SUB_Y)); exp_q.push_back(ea(1));
      wait_grant();
      repeat (4) tick();
      clear = 1'b1;
      @(negedge clk);
      check("rc_ready", arith_ready, 1);
      check("rc_nodone", req_done, 0);
      tick(); clear = 1'b0;
      wait_quiet();
      // unit not ready while idle
      tick(); nr_force = 1'b1; pend[0] += 1;
      exp_q.push_back(eg(0, X_MUL_X)); exp_q.push_back(ed(0));
      repeat (3) begin @(negedge clk); check("nr_en", arith_en, 0); end
      tick(); nr_force = 1'b0;
      @(negedge clk);
      check("nr_release", arith_en, 1);
      wait_quiet();
      // clear in IDLE blocks issue
      tick(); clear = 1'b1; pend[1] += 1;
      exp_q.push_back(eg(1, X_SUB_Y)); exp_q.push_back(ed(1));
      @(negedge clk);
      check("ci_valid", req_valid[1], 1);
      check("ci_grant", req_grant, 0);
      tick(); clear = 1'b0;
      wait_quiet();
      // reset mid-RUN after granting req0; rr must return to 0
      pend[0] += 1;
      exp_q.push_back(eg(0, X_MUL_X));
      wait_grant();
      tick(); rst = 1'b1;
      tick();
      @(negedge clk);
      check("mr_busy", busy, 0);
      tick(); rst = 1'b0; pend[0] += 1; pend[1] += 1;
      exp_q.push_back(eg(0, X_MUL_X)); exp_q.push_back(ed(0));
      exp_q.push_back(eg(1, X_SUB_Y)); exp_q.push_back(ed(1));
      wait_quiet();
      check("pre_rst_owner", owner, 1);
      do_reset();
      @(negedge clk);
      check("post_rst_owner", owner, 0);
`ifdef MOD_ARITH_ARB_LOCK_EN
      // locked chain on req1 holds off req0 despite rr favouring it
      req_lock[1] = 1'b1; op_r[1] = X_MUL_Y; pend[1] += 1;
      exp_q.push_back(eg(1, X_MUL_Y)); exp_q.push_back(ed(1));
      wait_grant();
      tick(); req_lock[1] = 1'b0; op_r[1] = X_ADD_Y; pend[1] += 1; pend[0] += 1;
      exp_q.push_back(eg(1, X_ADD_Y)); exp_q.push_back(ed(1));
      exp_q.push_back(eg(0, X_MUL_X)); exp_q.push_back(ed(0));
      wait_quiet();
`endif
      check("drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
